led_animator: RTL and testbench
===============================

LED_ANIMATOR -- requirements
Module: led_animator

Interface
REQ-001 SHALL have parameter LED_WIDTH, default 8, number of LEDs driven (even, 4..32).
REQ-002 SHALL have parameter REPEATS, default 3, repetitions per animation (1..15).
REQ-003 SHALL have parameter STEP_DIV, default 1, BALL_CLOCK cycles per animation frame (>=1).
REQ-004 SHALL have port BALL_CLOCK  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports goal_player_1, goal_player_2, win_player_1, win_player_2  input  1 each  event requests, sampled every cycle.
REQ-007 SHALL have port led  output  LED_WIDTH  registered LED pattern.
REQ-008 SHALL have port busy  output  1  high while an animation runs.
REQ-009 SHALL have port mode  output  3  current animation: 0 IDLE, 1 GOAL1, 2 GOAL2, 3 WIN1, 4 WIN2.

Function
REQ-010 SHALL be a two-state FSM (IDLE, RUN), with a mode register, frame counter, repetition counter, divider counter and one-deep pending register (valid + mode).
REQ-011 SHALL resolve simultaneous events by priority win_player_1 > win_player_2 > goal_player_1 > goal_player_2.
REQ-012 SHALL, on an event in IDLE at cycle t, present busy=1, mode=selected, frame=0, led=0, repetitions=REPEATS at t+1.
REQ-013 SHALL advance the frame when the divider reaches STEP_DIV-1, then clear the divider; divider clears on every animation start.
REQ-014 SHALL use, with W=LED_WIDTH, H=W/2, frame k: GOAL1 W+1 frames, k=0 blank, k>=1 only bit W-k lit.
REQ-015 SHALL use GOAL2 W+1 frames, k=0 blank, k>=1 only bit k-1 lit.
REQ-016 SHALL use WIN1 W frames: k=0 blank; k=1..H bits W-k and k-1 lit; k=H+1..W-1 bits H-1 through k all lit.
REQ-017 SHALL use WIN2 W frames: k=0..H as WIN1; k=H+1..W-1 bits W-1-k through H all lit.
REQ-018 SHALL, on the tick after the last frame, wrap frame to 0 (led=0) and decrement repetitions.
REQ-019 SHALL, when repetitions reach 0, start the pending animation (busy stays 1, pending cleared) if pending valid, else return to IDLE with led=0, busy=0, mode=0.
REQ-020 SHALL, on a win event during a GOAL animation, restart as that WIN at frame 0 on the next cycle and clear pending.
REQ-021 SHALL ignore win events during a WIN animation.
REQ-022 SHALL, on a goal event during RUN with no simultaneous win, store it in pending, overwriting any earlier pending entry.
REQ-023 SHALL treat events as levels: an input held high in IDLE retriggers immediately after completion.
REQ-024 SHALL hold led, mode and busy constant between frame ticks.

Reset
REQ-025 SHALL, with RESET high at a rising edge, set led=0, busy=0, mode=0, FSM IDLE, pending invalid, all counters 0, overriding any event that cycle.
REQ-026 SHALL ignore events on a cycle where RESET is high; first sampled on the cycle after RESET falls.

Verification (W=8, REPEATS=3, STEP_DIV=1 unless stated)
REQ-027 SHALL check: goal_player_1 one-cycle pulse in IDLE -> led 00,80,40,20,10,08,04,02,01 x3, busy high 27 cycles, then led=00, mode=0.
REQ-028 SHALL check: win_player_2 pulse -> led 00,81,42,24,18,1C,1E,1F x3, busy 24 cycles; win_player_1 gives 00,81,42,24,18,38,78,F8.
REQ-029 SHALL check: win_player_1 pulse at GOAL1 frame 3 (led=20), goal_player_2 pending -> next cycle mode=3, led=00, pending cleared, no GOAL2 afterwards.
REQ-030 SHALL check: goal_player_2 pulse during GOAL1 -> GOAL1 completes, GOAL2 frame 0 next cycle, busy never drops, mode 1->2.
REQ-031 SHALL check: all four inputs high for one cycle in IDLE -> mode=3 (WIN1), nothing pending.
REQ-032 SHALL check: STEP_DIV=4, each frame held exactly 4 cycles; RESET pulse mid-animation -> next cycle led=00, busy=0, mode=0, no resumption.

Source files
------------

// File: rtl/led_animator.sv
// ============================================================================
// Module      : led_animator
// Description : Goal/win LED animation sequencer with one-deep pending queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_animator #(
  parameter int LED_WIDTH = 8,
  parameter int REPEATS   = 3,
  parameter int STEP_DIV  = 1
) (
  input  logic                 BALL_CLOCK,
  input  logic                 RESET,
  input  logic                 goal_player_1,
  input  logic                 goal_player_2,
  input  logic                 win_player_1,
  input  logic                 win_player_2,
  output logic [LED_WIDTH-1:0] led,
  output logic                 busy,
  output logic [2:0]           mode
);

  localparam int c_frame_w = $clog2(LED_WIDTH + 1);
  localparam int c_div_w   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int c_half    = LED_WIDTH / 2;

  localparam logic [2:0] c_mode_idle  = 3'd0;
  localparam logic [2:0] c_mode_goal1 = 3'd1;
  localparam logic [2:0] c_mode_goal2 = 3'd2;
  localparam logic [2:0] c_mode_win1  = 3'd3;
  localparam logic [2:0] c_mode_win2  = 3'd4;

  localparam logic [c_frame_w-1:0] c_goal_last = c_frame_w'(LED_WIDTH);
  localparam logic [c_frame_w-1:0] c_win_last  = c_frame_w'(LED_WIDTH - 1);
  localparam logic [c_frame_w-1:0] c_frame_one = c_frame_w'(1);
  localparam logic [c_div_w-1:0]   c_div_last  = c_div_w'(STEP_DIV - 1);
  localparam logic [c_div_w-1:0]   c_div_one   = c_div_w'(1);
  localparam logic [3:0]           c_repeats   = 4'(REPEATS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [2:0]             r_mode, w_mode_nxt;
  logic [c_frame_w-1:0]   r_frame, w_frame_nxt;
  logic [3:0]             r_reps, w_reps_nxt;
  logic [c_div_w-1:0]     r_div, w_div_nxt;
  logic                   r_pend_valid, w_pend_valid_nxt;
  logic [2:0]             r_pend_mode, w_pend_mode_nxt;
  logic [LED_WIDTH-1:0]   r_led;

  logic                   w_win, w_goal, w_any;
  logic [2:0]             w_win_mode, w_goal_mode, w_evt_mode;
  logic                   w_in_goal, w_tick;
  logic [c_frame_w-1:0]   w_last_frame;

  function automatic logic [LED_WIDTH-1:0] frame_pattern(
    input logic [2:0]           m,
    input logic [c_frame_w-1:0] f
  );
    logic [LED_WIDTH-1:0] p;
    int                   k;
    p = '0;
    k = int'(f);
    for (int i = 0; i < LED_WIDTH; i++) begin
      case (m)
        c_mode_goal1: p[i] = (k >= 1) && (i == LED_WIDTH - k);
        c_mode_goal2: p[i] = (k >= 1) && (i == k - 1);
        c_mode_win1, c_mode_win2: begin
          if (k >= 1 && k <= c_half)
            p[i] = (i == LED_WIDTH - k) || (i == k - 1);
          else if (k > c_half)
            // Second half fills a bar outward from the centre towards the winner's side.
            p[i] = (m == c_mode_win1) ? (i >= c_half - 1 && i <= k)
                                      : (i >= LED_WIDTH - 1 - k && i <= c_half);
          else
            p[i] = 1'b0;
        end
        default: p[i] = 1'b0;
      endcase
    end
    return p;
  endfunction

  assign w_win        = win_player_1 | win_player_2;
  assign w_goal       = goal_player_1 | goal_player_2;
  assign w_any        = w_win | w_goal;
  assign w_win_mode   = win_player_1 ? c_mode_win1 : c_mode_win2;
  assign w_goal_mode  = goal_player_1 ? c_mode_goal1 : c_mode_goal2;
  assign w_evt_mode   = w_win ? w_win_mode : w_goal_mode;
  assign w_in_goal    = (r_mode == c_mode_goal1) || (r_mode == c_mode_goal2);
  assign w_tick       = (r_div == c_div_last);
  assign w_last_frame = w_in_goal ? c_goal_last : c_win_last;

  always_comb begin
    w_state_nxt      = r_state;
    w_mode_nxt       = r_mode;
    w_frame_nxt      = r_frame;
    w_reps_nxt       = r_reps;
    w_div_nxt        = r_div;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_mode_nxt  = r_pend_mode;

    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt      = ST_RUN;
          w_mode_nxt       = w_evt_mode;
          w_frame_nxt      = '0;
          w_reps_nxt       = c_repeats;
          w_div_nxt        = '0;
          w_pend_valid_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        if (w_win && w_in_goal) begin
          w_mode_nxt       = w_win_mode;
          w_frame_nxt      = '0;
          w_reps_nxt       = c_repeats;
          w_div_nxt        = '0;
          w_pend_valid_nxt = 1'b0;
        end else begin
          if (w_goal && !w_win) begin
            w_pend_valid_nxt = 1'b1;
            w_pend_mode_nxt  = w_goal_mode;
          end
          if (w_tick) begin
            w_div_nxt = '0;
            if (r_frame == w_last_frame) begin
              w_frame_nxt = '0;
              w_reps_nxt  = r_reps - 4'd1;
              if (r_reps == 4'd1) begin
                // A goal arriving on this very cycle is already folded into pending.
                if (w_pend_valid_nxt) begin
                  w_mode_nxt       = w_pend_mode_nxt;
                  w_reps_nxt       = c_repeats;
                  w_pend_valid_nxt = 1'b0;
                end else begin
                  w_state_nxt      = ST_IDLE;
                  w_mode_nxt       = c_mode_idle;
                  w_reps_nxt       = '0;
                end
              end
            end else begin
              w_frame_nxt = r_frame + c_frame_one;
            end
          end else begin
            w_div_nxt = r_div + c_div_one;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge BALL_CLOCK) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_mode       <= c_mode_idle;
      r_frame      <= '0;
      r_reps       <= '0;
      r_div        <= '0;
      r_pend_valid <= 1'b0;
      r_pend_mode  <= c_mode_idle;
      r_led        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mode       <= w_mode_nxt;
      r_frame      <= w_frame_nxt;
      r_reps       <= w_reps_nxt;
      r_div        <= w_div_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_mode  <= w_pend_mode_nxt;
      r_led        <= frame_pattern(w_mode_nxt, w_frame_nxt);
    end
  end

  assign led  = r_led;
  assign busy = (r_state == ST_RUN);
  assign mode = r_mode;

endmodule

`default_nettype wire

// File: tb/tb_led_animator.sv
// ============================================================================
// Module      : tb_led_animator
// Description : Table-driven, scoreboard-checked bench for led_animator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_animator;

  typedef struct packed {
    logic [7:0] led;
    logic       busy;
    logic [2:0] mode;
  } exp_t;

  typedef struct {
    logic [3:0]      ev;    // {win1, win2, goal1, goal2}
    logic [2:0]      mode;
    int              nfr;
    logic [8:0][7:0] pat;   // pat[k] = led at frame k
  } vec_t;

  logic       BALL_CLOCK = 1'b0;
  logic       RESET, g1, g2, w1, w2;
  logic [7:0] led0;
  logic       busy0;
  logic [2:0] mode0;

  logic       rst4, g1_4;
  logic [7:0] led4;
  logic       busy4;
  logic [2:0] mode4;

  exp_t  q0[$];
  exp_t  q4[$];
  vec_t  vecs[5];
  int    checks = 0;
  int    errors = 0;
  string tag = "reset";

  localparam logic [8:0][7:0] c_pat_goal1 = {8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h00};
  localparam logic [8:0][7:0] c_pat_goal2 = {8'h80,8'h40,8'h20,8'h10,8'h08,8'h04,8'h02,8'h01,8'h00};
  localparam logic [8:0][7:0] c_pat_win1  = {8'h00,8'hF8,8'h78,8'h38,8'h18,8'h24,8'h42,8'h81,8'h00};
  localparam logic [8:0][7:0] c_pat_win2  = {8'h00,8'h1F,8'h1E,8'h1C,8'h18,8'h24,8'h42,8'h81,8'h00};

  always #5 BALL_CLOCK = ~BALL_CLOCK;

  led_animator #(.LED_WIDTH(8), .REPEATS(3), .STEP_DIV(1)) u_dut (
    .BALL_CLOCK    (BALL_CLOCK),
    .RESET         (RESET),
    .goal_player_1 (g1),
    .goal_player_2 (g2),
    .win_player_1  (w1),
    .win_player_2  (w2),
    .led           (led0),
    .busy          (busy0),
    .mode          (mode0)
  );

  led_animator #(.LED_WIDTH(8), .REPEATS(3), .STEP_DIV(4)) u_dut4 (
    .BALL_CLOCK    (BALL_CLOCK),
    .RESET         (rst4),
    .goal_player_1 (g1_4),
    .goal_player_2 (1'b0),
    .win_player_1  (1'b0),
    .win_player_2  (1'b0),
    .led           (led4),
    .busy          (busy4),
    .mode          (mode4)
  );

  task automatic push(input int sel, input logic [7:0] l, input logic b, input logic [2:0] m);
    exp_t e;
    e = {l, b, m};
    if (sel == 0) q0.push_back(e);
    else          q4.push_back(e);
  endtask

  task automatic push_anim(input logic [8:0][7:0] pat, input int nfr, input logic [2:0] m);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < nfr; k++)
        push(0, pat[k], 1'b1, m);
  endtask

  task automatic step_chk(input int sel);
    exp_t e, got;
    @(posedge BALL_CLOCK);
    #1;
    got = (sel == 0) ? {led0, busy0, mode0} : {led4, busy4, mode4};
    checks++;
    if ((sel == 0 && q0.size() == 0) || (sel != 0 && q4.size() == 0)) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got led=%h busy=%b mode=%0d", tag, got.led, got.busy, got.mode);
    end else begin
      e = (sel == 0) ? q0.pop_front() : q4.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s @%0t: got led=%h busy=%b mode=%0d, expected led=%h busy=%b mode=%0d",
                 tag, $time, got.led, got.busy, got.mode, e.led, e.busy, e.mode);
      end
    end
  endtask

  task automatic flush(input int sel);
    while ((sel == 0 && q0.size() > 0) || (sel != 0 && q4.size() > 0))
      step_chk(sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{ev: 4'b0010, mode: 3'd1, nfr: 9, pat: c_pat_goal1};
    vecs[1] = '{ev: 4'b0001, mode: 3'd2, nfr: 9, pat: c_pat_goal2};
    vecs[2] = '{ev: 4'b1000, mode: 3'd3, nfr: 8, pat: c_pat_win1};
    vecs[3] = '{ev: 4'b0100, mode: 3'd4, nfr: 8, pat: c_pat_win2};
    vecs[4] = '{ev: 4'b1111, mode: 3'd3, nfr: 8, pat: c_pat_win1};

    RESET = 1'b1; rst4 = 1'b1;
    g1 = 1'b0; g2 = 1'b0; w1 = 1'b0; w2 = 1'b0; g1_4 = 1'b0;

    // Reset state, including an event asserted while reset is held.
    push(0, 8'h00, 1'b0, 3'd0);
    step_chk(0);
    w1 = 1'b1;
    push(0, 8'h00, 1'b0, 3'd0);
    step_chk(0);
    RESET = 1'b0; w1 = 1'b0;
    push(0, 8'h00, 1'b0, 3'd0);
    step_chk(0);

    // Single-pulse animations from IDLE.
    for (int v = 0; v < 5; v++) begin
      $sformat(tag, "vec%0d", v);
      {w1, w2, g1, g2} = vecs[v].ev;
      push_anim(vecs[v].pat, vecs[v].nfr, vecs[v].mode);
      push(0, 8'h00, 1'b0, 3'd0);
      step_chk(0);
      {w1, w2, g1, g2} = 4'b0000;
      flush(0);
    end

    // Win pre-empts a goal animation and discards the pending goal.
    tag = "win_preempt";
    g1 = 1'b1;
    push(0, 8'h00, 1'b1, 3'd1); step_chk(0);
    g1 = 1'b0; g2 = 1'b1;
    push(0, 8'h80, 1'b1, 3'd1); step_chk(0);
    g2 = 1'b0;
    push(0, 8'h40, 1'b1, 3'd1); step_chk(0);
    push(0, 8'h20, 1'b1, 3'd1); step_chk(0);
    w1 = 1'b1;
    push_anim(c_pat_win1, 8, 3'd3);
    push(0, 8'h00, 1'b0, 3'd0);
    push(0, 8'h00, 1'b0, 3'd0);
    step_chk(0);
    w1 = 1'b0;
    flush(0);

    // Goal queued during a goal animation chains without dropping busy.
    tag = "goal_chain";
    g1 = 1'b1;
    push_anim(c_pat_goal1, 9, 3'd1);
    step_chk(0);
    g1 = 1'b0; g2 = 1'b1;
    step_chk(0);
    g2 = 1'b0;
    push_anim(c_pat_goal2, 9, 3'd2);
    push(0, 8'h00, 1'b0, 3'd0);
    flush(0);

    // Held win is ignored while its own animation runs, then retriggers.
    tag = "win_held";
    w2 = 1'b1;
    push_anim(c_pat_win2, 8, 3'd4);
    push(0, 8'h00, 1'b0, 3'd0);
    push(0, 8'h00, 1'b1, 3'd4);
    flush(0);
    w2 = 1'b0;
    for (int k = 1; k < 8; k++) push(0, c_pat_win2[k], 1'b1, 3'd4);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 8; k++) push(0, c_pat_win2[k], 1'b1, 3'd4);
    push(0, 8'h00, 1'b0, 3'd0);
    flush(0);

    // STEP_DIV=4: every frame lasts four cycles; reset aborts mid-animation.
    tag = "div4";
    rst4 = 1'b0;
    push(1, 8'h00, 1'b0, 3'd0);
    step_chk(1);
    g1_4 = 1'b1;
    repeat (4) push(1, 8'h00, 1'b1, 3'd1);
    repeat (4) push(1, 8'h80, 1'b1, 3'd1);
    repeat (2) push(1, 8'h40, 1'b1, 3'd1);
    step_chk(1);
    g1_4 = 1'b0;
    flush(1);
    tag = "div4_reset";
    rst4 = 1'b1;
    push(1, 8'h00, 1'b0, 3'd0);
    step_chk(1);
    rst4 = 1'b0;
    repeat (8) push(1, 8'h00, 1'b0, 3'd0);
    flush(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
